// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: line parity modes and the framing FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // The reserved encoding 2'b11 falls back to no parity.
    function automatic parity_mode_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register storage, combinational read of the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; framing options are captured per frame at pop time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 busy,
    output logic                 uart_txd,
    output tx_state_e            dbg_state
);

    localparam int CLKS_PER_BIT           = CLK_HZ / BAUD;
    localparam int CNT_W                  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST       = 3'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 bit_end;
    parity_mode_e         mode;

    tx_state_e            state_q;
    logic [CNT_W-1:0]     baud_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 stop2_q;
    logic                 txd_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign mode       = decode_parity(parity_mode);
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign bit_end    = (baud_cnt_q == CNT_LAST);
    assign tx_ready   = !fifo_full;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_txd   = txd_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            if (state_q != ST_IDLE) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    txd_q      <= 1'b1;
                    baud_cnt_q <= '0;
                    // Data and framing options are frozen here so later input changes
                    // cannot disturb a frame already on the line.
                    if (pop) begin
                        state_q    <= ST_START;
                        txd_q      <= 1'b0;
                        shift_q    <= fifo_rdata;
                        par_en_q   <= (mode != PAR_NONE);
                        par_bit_q  <= (^fifo_rdata) ^ (mode == PAR_ODD);
                        two_stop_q <= two_stop;
                        stop2_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                            txd_q   <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
